multiword_sub_seq: RTL and testbench
====================================

// Module: multiword_sub_seq
// PURPOSE
//  Sequencer for multi-precision subtraction (R = A - B, WORDS*WORD_W bits) on the 32-bit
//  combinational subtract-with-carry stage. Feeds that stage one word per cycle (LS word
//  first) via sub_a/sub_b/sub_cin, chains its carry-out back as next carry-in, and
//  collects sub_result into the wide result. Sits between the ALU issue logic and the stage.
// PARAMETERS
//  WORDS   4   number of WORD_W words per operand; legal range >= 1
//  WORD_W  32  word width; must equal the subtract stage width (32)
// PORTS
//  clk         in   1               clock, all state on rising edge
//  rst         in   1               synchronous reset, active-high
//  in_valid    in   1               operands offered
//  in_ready    out  1               block accepts operands (high only in IDLE)
//  a_in        in   WORDS*WORD_W    minuend
//  b_in        in   WORDS*WORD_W    subtrahend
//  out_valid   out  1               result held valid
//  out_ready   in   1               consumer takes result
//  result      out  WORDS*WORD_W    A - B mod 2^(WORDS*WORD_W)
//  borrow_out  out  1               1 when A < B unsigned (= ~final carry)
//  sub_a       out  WORD_W          word to subtract stage num1
//  sub_b       out  WORD_W          word to subtract stage num2 (stage inverts it)
//  sub_cin     out  1               stage carry-in; 1 = no borrow
//  sub_result  in   WORD_W          stage result
//  sub_cout    in   1               stage carry-out; 0 = borrow
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. Reset: state IDLE, out_valid=0, result=0,
//    borrow_out=0, word counter=0, carry reg=1; in_ready=1 from the first post-reset cycle.
//  - FSM IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE), combinational.
//  - IDLE: on in_valid&&in_ready capture a_in,b_in; carry<=1; cnt<=0; go RUN.
//  - RUN: sub_a/sub_b = current LS word of the operand shift regs, sub_cin = carry.
//    Edge: shift sub_result into the top of the result shift reg; carry<=sub_cout;
//    operands shift right WORD_W; cnt++. When cnt==WORDS-1, go DONE.
//  - DONE: out_valid=1, result/borrow_out (= ~carry) stable until out_ready; on
//    out_valid&&out_ready go IDLE. Inputs ignored in RUN/DONE.
//  - Latency: out_valid rises WORDS edges after the accepting edge; throughput one op per
//    WORDS+2 cycles (mandatory IDLE bubble after DONE, even if in_valid is already high).
//  - Outside RUN: sub_a=0, sub_b=0, sub_cin=1.
//  - WORDS==1: RUN lasts one cycle; identical rules.
//  - rst in any state (incl. mid-RUN) discards the op; no partial result is ever presented.
// CONFIGURATION
//  MWSUB_FLAGS_EN defined: extra outputs zero_flag (result==0) and ovf_flag (signed overflow:
//  (a_top^b_top)&(a_top^r_top) on MS bits), registered with the final word, valid with
//  out_valid, reset 0. Undefined: these ports and their logic do not exist; all else identical.
// STRUCTURE
//  - Package mwsub_pkg: state enum typedef (IDLE, RUN, DONE), WORD_W default constant.
//  - Sub-module mwsub_shift_reg (WIDTH, STEP): loadable right-shift register with
//    load/shift/serial-in; instantiated three times (A, B, result).
//  - The subtract stage is instantiated by the parent, not inside this block.
// TESTING (WORDS=4, bench models the subtract stage)
//  - A=5, B=3 -> result=2, borrow_out=0, out_valid 4 edges after accept.
//  - A=0, B=1 -> result=all ones (128b), borrow_out=1.
//  - A=2^96, B=1 -> result=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, borrow_out=0
//    (borrow ripples across 3 words).
//  - out_ready=0 for 10 cycles in DONE -> result, borrow_out, out_valid stable;
//    in_ready=0; in_valid pulses ignored.
//  - rst after 2 RUN cycles -> next cycle out_valid=0, in_ready=1; next op A=9, B=4 -> 5.
//  - MWSUB_FLAGS_EN: A=2^127, B=1 -> ovf_flag=1, zero_flag=0; A=B=0x1234 -> zero_flag=1, ovf_flag=0.

Source files
------------

// File: rtl/mwsub_pkg.sv
// Purpose: shared types and constants for the multi-word subtract sequencer.
// Contents: MWSUB_WORD_W (width of the subtract-with-carry stage) and the
//           sequencer state enum (IDLE, RUN, DONE).
package mwsub_pkg;

    localparam int unsigned MWSUB_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mwsub_state_e;

endpackage

// File: rtl/mwsub_shift_reg.sv
// Purpose: loadable right-shift register. Each shift moves the contents down
//          by STEP bits and inserts serial_in_i at the top.
//          Load has priority over shift.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears to zero)
//   load_i        parallel load of load_data_i
//   shift_i       shift right by STEP, serial_in_i enters at the MS end
//   load_data_i   parallel load value (WIDTH)
//   serial_in_i   word shifted in (STEP)
//   data_o        full register contents (WIDTH)
//   word_o        least-significant STEP bits of the register
module mwsub_shift_reg #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned STEP  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic [STEP-1:0]  serial_in_i,
    output logic [WIDTH-1:0] data_o,
    output logic [STEP-1:0]  word_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] shifted_c;

    // A single-word register simply takes the incoming word on a shift.
    generate
        if (WIDTH > STEP) begin : g_multi
            assign shifted_c = {serial_in_i, data_q[WIDTH-1:STEP]};
        end else begin : g_single
            assign shifted_c = WIDTH'(serial_in_i);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (shift_i) begin
            data_q <= shifted_c;
        end
    end

    assign data_o = data_q;
    assign word_o = data_q[STEP-1:0];

endmodule

// File: rtl/multiword_sub_seq.sv
// Purpose: sequences a WORDS*WORD_W-bit subtraction R = A - B through an
//          external 32-bit subtract-with-carry stage, one word per cycle,
//          least-significant word first, chaining the stage carry-out back
//          in as the next carry-in (carry 1 = no borrow).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a_in, b_in           minuend / subtrahend (WORDS*WORD_W)
//   out_valid/out_ready  result handshake (result held while out_valid)
//   result               A - B mod 2^(WORDS*WORD_W)
//   borrow_out           1 when A < B unsigned
//   sub_a, sub_b, sub_cin    drive to the subtract stage (idle: 0, 0, 1)
//   sub_result, sub_cout     returned from the subtract stage
// Configuration: define MWSUB_FLAGS_EN to add zero_flag and ovf_flag outputs
//   (result == 0, signed overflow), valid together with out_valid.
module multiword_sub_seq
    import mwsub_pkg::*;
#(
    parameter int unsigned WORDS  = 4,
    parameter int unsigned WORD_W = MWSUB_WORD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDS*WORD_W-1:0] a_in,
    input  logic [WORDS*WORD_W-1:0] b_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WORD_W-1:0] result,
    output logic                    borrow_out,
    output logic [WORD_W-1:0]       sub_a,
    output logic [WORD_W-1:0]       sub_b,
    output logic                    sub_cin,
    input  logic [WORD_W-1:0]       sub_result,
`ifdef MWSUB_FLAGS_EN
    input  logic                    sub_cout,
    output logic                    zero_flag,
    output logic                    ovf_flag
`else
    input  logic                    sub_cout
`endif
);

    localparam int unsigned TOTAL_W = WORDS * WORD_W;
    localparam int unsigned CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

    mwsub_state_e     state_q;
    mwsub_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             out_valid_q;
    logic             borrow_q;

    logic             load_c;
    logic             shift_c;
    logic             last_c;
    logic             release_c;

    logic [WORD_W-1:0]  a_word;
    logic [WORD_W-1:0]  b_word;
    logic [TOTAL_W-1:0] a_all_unused;
    logic [TOTAL_W-1:0] b_all_unused;
    logic [WORD_W-1:0]  res_word_unused;
    logic [TOTAL_W-1:0] res_q;

    // Next-state and per-cycle datapath controls.
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        last_c    = 1'b0;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift_c = 1'b1;
                if (cnt_q == CNT_W'(WORDS - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, word counter, carry chain and result-side status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b1;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_c) begin
                cnt_q   <= '0;
                carry_q <= 1'b1;
            end
            if (shift_c) begin
                cnt_q   <= cnt_q + CNT_W'(1);
                carry_q <= sub_cout;
            end
            if (last_c) begin
                out_valid_q <= 1'b1;
                borrow_q    <= ~sub_cout;
            end
            if (release_c) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    mwsub_shift_reg #(.WIDTH(TOTAL_W), .STEP(WORD_W)) u_a_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_c),
        .shift_i     (shift_c),
        .load_data_i (a_in),
        .serial_in_i ('0),
        .data_o      (a_all_unused),
        .word_o      (a_word)
    );

    mwsub_shift_reg #(.WIDTH(TOTAL_W), .STEP(WORD_W)) u_b_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_c),
        .shift_i     (shift_c),
        .load_data_i (b_in),
        .serial_in_i ('0),
        .data_o      (b_all_unused),
        .word_o      (b_word)
    );

    // Stage results enter at the top; after WORDS shifts the LS word sits at the bottom.
    mwsub_shift_reg #(.WIDTH(TOTAL_W), .STEP(WORD_W)) u_res_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .shift_i     (shift_c),
        .load_data_i ('0),
        .serial_in_i (sub_result),
        .data_o      (res_q),
        .word_o      (res_word_unused)
    );

    // Stage drive is parked at 0 - 0 with no borrow outside RUN.
    always_comb begin
        sub_a   = '0;
        sub_b   = '0;
        sub_cin = 1'b1;
        if (state_q == RUN) begin
            sub_a   = a_word;
            sub_b   = b_word;
            sub_cin = carry_q;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign result     = res_q;
    assign borrow_out = borrow_q;

`ifdef MWSUB_FLAGS_EN
    logic zero_acc_q;
    logic zero_flag_q;
    logic ovf_flag_q;

    // Zero is accumulated word by word; overflow uses the MS bits of the final word.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_acc_q  <= 1'b1;
            zero_flag_q <= 1'b0;
            ovf_flag_q  <= 1'b0;
        end else begin
            if (load_c) begin
                zero_acc_q <= 1'b1;
            end
            if (shift_c) begin
                zero_acc_q <= zero_acc_q & (sub_result == '0);
            end
            if (last_c) begin
                zero_flag_q <= zero_acc_q & (sub_result == '0);
                ovf_flag_q  <= (sub_a[WORD_W-1] ^ sub_b[WORD_W-1])
                             & (sub_a[WORD_W-1] ^ sub_result[WORD_W-1]);
            end
        end
    end

    assign zero_flag = zero_flag_q;
    assign ovf_flag  = ovf_flag_q;
`endif

endmodule

// File: tb/tb_multiword_sub_seq.sv
// Bench for multiword_sub_seq (WORDS=4): models the 32-bit subtract stage and
// compares against a wide-arithmetic reference (A - B, A < B).
module tb_multiword_sub_seq;

    localparam int unsigned WORDS   = 4;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TOTAL_W = WORDS * WORD_W;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [TOTAL_W-1:0] a_in;
    logic [TOTAL_W-1:0] b_in;
    logic               out_valid;
    logic               out_ready;
    logic [TOTAL_W-1:0] result;
    logic               borrow_out;
    logic [WORD_W-1:0]  sub_a;
    logic [WORD_W-1:0]  sub_b;
    logic               sub_cin;
    logic [WORD_W-1:0]  sub_result;
    logic               sub_cout;
`ifdef MWSUB_FLAGS_EN
    logic               zero_flag;
    logic               ovf_flag;
`endif

    int checks;
    int errors;

    multiword_sub_seq #(.WORDS(WORDS), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .borrow_out (borrow_out),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_cin    (sub_cin),
        .sub_result (sub_result),
`ifdef MWSUB_FLAGS_EN
        .sub_cout   (sub_cout),
        .zero_flag  (zero_flag),
        .ovf_flag   (ovf_flag)
`else
        .sub_cout   (sub_cout)
`endif
    );

    // Subtract stage: num1 + ~num2 + cin.
    logic [WORD_W:0] stage_sum;
    assign stage_sum  = {1'b0, sub_a} + {1'b0, ~sub_b} + {{WORD_W{1'b0}}, sub_cin};
    assign sub_result = stage_sum[WORD_W-1:0];
    assign sub_cout   = stage_sum[WORD_W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [TOTAL_W-1:0] got,
                         input logic [TOTAL_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [TOTAL_W-1:0] rnd_wide();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full transaction: offer, measure latency, check result, hold in DONE, release.
    task automatic do_op(input logic [TOTAL_W-1:0] a, input logic [TOTAL_W-1:0] b,
                         input int hold);
        logic [TOTAL_W-1:0] exp_r;
        logic               exp_bor;
        int                 n;
        exp_r   = a - b;
        exp_bor = (a < b);
        @(negedge clk);
        check("in_ready_idle", TOTAL_W'(in_ready), TOTAL_W'(1));
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = rnd_wide();
        b_in     = rnd_wide();
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", TOTAL_W'(n), TOTAL_W'(WORDS));
        check("result", result, exp_r);
        check("borrow", TOTAL_W'(borrow_out), TOTAL_W'(exp_bor));
        check("in_ready_done", TOTAL_W'(in_ready), TOTAL_W'(0));
`ifdef MWSUB_FLAGS_EN
        check("zero_flag", TOTAL_W'(zero_flag), TOTAL_W'(exp_r == '0));
        check("ovf_flag", TOTAL_W'(ovf_flag),
              TOTAL_W'((a[TOTAL_W-1] ^ b[TOTAL_W-1]) & (a[TOTAL_W-1] ^ exp_r[TOTAL_W-1])));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            a_in     = rnd_wide();
            b_in     = rnd_wide();
            @(posedge clk);
            #1;
            check("hold_valid", TOTAL_W'(out_valid), TOTAL_W'(1));
            check("hold_result", result, exp_r);
            check("hold_borrow", TOTAL_W'(borrow_out), TOTAL_W'(exp_bor));
            check("hold_in_ready", TOTAL_W'(in_ready), TOTAL_W'(0));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", TOTAL_W'(out_valid), TOTAL_W'(0));
        check("release_in_ready", TOTAL_W'(in_ready), TOTAL_W'(1));
    endtask

    initial begin
        logic [TOTAL_W-1:0] ra;
        logic [TOTAL_W-1:0] rb;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", TOTAL_W'(out_valid), TOTAL_W'(0));
        check("rst_result", result, '0);
        check("rst_borrow", TOTAL_W'(borrow_out), TOTAL_W'(0));
        check("rst_in_ready", TOTAL_W'(in_ready), TOTAL_W'(1));
        check("idle_sub_a", TOTAL_W'(sub_a), '0);
        check("idle_sub_cin", TOTAL_W'(sub_cin), TOTAL_W'(1));

        do_op(TOTAL_W'(5), TOTAL_W'(3), 0);
        do_op('0, TOTAL_W'(1), 0);
        do_op(TOTAL_W'(1) << 96, TOTAL_W'(1), 0);
        do_op(rnd_wide(), rnd_wide(), 10);
        do_op(TOTAL_W'(1) << 127, TOTAL_W'(1), 0);
        do_op(TOTAL_W'(16'h1234), TOTAL_W'(16'h1234), 0);

        // Reset two cycles into RUN discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = rnd_wide();
        b_in     = rnd_wide();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_rst_valid", TOTAL_W'(out_valid), TOTAL_W'(0));
        check("midrun_rst_in_ready", TOTAL_W'(in_ready), TOTAL_W'(1));
        check("midrun_rst_result", result, '0);
        do_op(TOTAL_W'(9), TOTAL_W'(4), 0);

        for (int k = 0; k < 20; k++) begin
            ra = rnd_wide();
            rb = rnd_wide();
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb[TOTAL_W-1:WORD_W] = ra[TOTAL_W-1:WORD_W];
                default: ;
            endcase
            do_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
